// File: rtl/ps2_scan_fifo.sv
// PS/2 keyboard receiver feeding a first-word-fall-through scan-code FIFO.
// Frames are checked for odd parity, stop bit and inter-edge timeout; 0xF0 can be folded into a break tag.
module ps2_scan_fifo #(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int BREAK_MERGE    = 1
) (
    input  logic                          Clock_50,
    input  logic                          Resetn,
    input  logic                          PS2_clock,
    input  logic                          PS2_data,
    input  logic                          rd_en,
    input  logic                          clear_err,
    output logic [7:0]                    code_data,
    output logic                          code_break,
    output logic                          code_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic [7:0]                    err_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [AW:0]   DEPTH_FULL = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    logic          clk_s1_q, clk_s2_q, clk_prev_q, dat_s1_q, dat_s2_q;
    logic          fall;
    state_t        state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          parity_q, parity_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          break_pend_q, break_pend_d;
    logic          timeout_hit, frame_done, frame_good, is_f0, push_req, set_break, err_evt;

    logic [8:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic          pop_ok, push_ok, overflow_q, overflow_d;
    logic [7:0]    err_cnt_q, err_cnt_d;
    logic [8:0]    head;

    // Synchronisers idle high so a reset never manufactures a falling edge.
    always_ff @(posedge Clock_50 or negedge Resetn) begin
        if (!Resetn) begin
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            clk_prev_q <= 1'b1;
            dat_s1_q   <= 1'b1;
            dat_s2_q   <= 1'b1;
        end else begin
            clk_s1_q   <= PS2_clock;
            clk_s2_q   <= clk_s1_q;
            clk_prev_q <= clk_s2_q;
            dat_s1_q   <= PS2_data;
            dat_s2_q   <= dat_s1_q;
        end
    end

    assign fall        = clk_prev_q & ~clk_s2_q;
    assign timeout_hit = (state_q != S_IDLE) && !fall && (to_cnt_q == TO_LAST);

    always_ff @(posedge Clock_50 or negedge Resetn) begin
        if (!Resetn) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (fall && !dat_s2_q)         state_d = S_DATA;
            S_DATA:   if (fall && bit_cnt_q == 3'd7) state_d = S_PARITY;
            S_PARITY: if (fall)                      state_d = S_STOP;
            S_STOP:   if (fall)                      state_d = S_IDLE;
            default:                                 state_d = S_IDLE;
        endcase
        if (timeout_hit) state_d = S_IDLE;
    end

    always_comb begin
        frame_done = (state_q == S_STOP) && fall;
        frame_good = frame_done && dat_s2_q && (^{parity_q, shift_q});
        is_f0      = (BREAK_MERGE != 0) && (shift_q == 8'hF0);
        push_req   = frame_good && !is_f0;
        set_break  = frame_good && is_f0;
        err_evt    = (frame_done && !frame_good) || timeout_hit;
    end

    always_comb begin
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        parity_d     = parity_q;
        to_cnt_d     = (state_q == S_IDLE || fall || timeout_hit) ? '0 : to_cnt_q + TW'(1);
        break_pend_d = set_break ? 1'b1 : (push_req ? 1'b0 : break_pend_q);
        if (fall) begin
            if (state_q == S_IDLE) bit_cnt_d = 3'd0;
            if (state_q == S_DATA) begin
                shift_d   = {dat_s2_q, shift_q[7:1]};
                bit_cnt_d = bit_cnt_q + 3'd1;
            end
            if (state_q == S_PARITY) parity_d = dat_s2_q;
        end
    end

    always_ff @(posedge Clock_50 or negedge Resetn) begin
        if (!Resetn) begin
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            parity_q     <= 1'b0;
            to_cnt_q     <= '0;
            break_pend_q <= 1'b0;
        end else begin
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            parity_q     <= parity_d;
            to_cnt_q     <= to_cnt_d;
            break_pend_q <= break_pend_d;
        end
    end

    // A pop frees the head slot in the same edge, so a full FIFO still accepts a concurrent push.
    always_comb begin
        pop_ok     = rd_en && (count_q != '0);
        push_ok    = push_req && ((count_q != DEPTH_FULL) || pop_ok);
        count_d    = count_q;
        if (push_ok && !pop_ok) count_d = count_q + (AW+1)'(1);
        if (!push_ok && pop_ok) count_d = count_q - (AW+1)'(1);
        overflow_d = clear_err ? 1'b0 : ((push_req && !push_ok) ? 1'b1 : overflow_q);
        err_cnt_d  = err_cnt_q;
        if (err_evt && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
        if (clear_err) err_cnt_d = 8'd0;
    end

    always_ff @(posedge Clock_50) begin
        if (push_ok) mem_q[wr_ptr_q] <= {break_pend_q, shift_q};
    end

    always_ff @(posedge Clock_50 or negedge Resetn) begin
        if (!Resetn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q    <= count_d;
            overflow_q <= overflow_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign head       = mem_q[rd_ptr_q];
    assign code_valid = (count_q != '0);
    assign code_data  = code_valid ? head[7:0] : 8'h00;
    assign code_break = code_valid ? head[8] : 1'b0;
    assign fifo_count = count_q;
    assign overflow   = overflow_q;
    assign err_count  = err_cnt_q;

endmodule

// File: tb/tb_ps2_scan_fifo.sv
// Directed bench for ps2_scan_fifo: one merging depth-4 instance and one non-merging depth-8 instance
// share the same PS/2 pins; expected values are hand-computed constants.
module tb_ps2_scan_fifo;

    localparam int HALF = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_c = 1'b1;
    logic       ps2_d = 1'b1;
    logic       rd_en = 1'b0;
    logic       rd_nm = 1'b0;
    logic       clr = 1'b0;

    logic [7:0] data_a, err_a, data_b, err_b;
    logic       brk_a, val_a, ovf_a, brk_b, val_b, ovf_b;
    logic [2:0] cnt_a;
    logic [3:0] cnt_b;

    int n_checks = 0;
    int n_pass   = 0;

    always #10 clk = ~clk;

    ps2_scan_fifo #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(200), .BREAK_MERGE(1)) dut (
        .Clock_50(clk), .Resetn(rst_n), .PS2_clock(ps2_c), .PS2_data(ps2_d),
        .rd_en(rd_en), .clear_err(clr),
        .code_data(data_a), .code_break(brk_a), .code_valid(val_a),
        .fifo_count(cnt_a), .overflow(ovf_a), .err_count(err_a)
    );

    ps2_scan_fifo #(.FIFO_DEPTH(8), .TIMEOUT_CYCLES(200), .BREAK_MERGE(0)) dut_nm (
        .Clock_50(clk), .Resetn(rst_n), .PS2_clock(ps2_c), .PS2_data(ps2_d),
        .rd_en(rd_nm), .clear_err(clr),
        .code_data(data_b), .code_break(brk_b), .code_valid(val_b),
        .fifo_count(cnt_b), .overflow(ovf_b), .err_count(err_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
            $display("ok   %-16s = 0x%0h", tag, got);
        end else begin
            $display("FAIL %-16s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ps2_bit(input logic v);
        @(negedge clk);
        ps2_d = v;
        tick(HALF);
        ps2_c = 1'b0;
        tick(HALF);
        ps2_c = 1'b1;
        tick(HALF);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop, input int nbits);
        logic [10:0] fr;
        fr = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) ps2_bit(fr[i]);
    endtask

    // Stop bit with cycle-exact control: optional latency probes, optional pop on the push edge.
    task automatic send_stop_timed(input logic chk_lat, input logic pop_now);
        tick(1);
        ps2_d = 1'b1;
        tick(HALF);
        ps2_c = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        if (chk_lat) check("lat_edge2_valid", 32'(val_a), 32'd0);
        @(negedge clk);
        if (pop_now) rd_en = 1'b1;
        @(posedge clk);
        #1;
        if (chk_lat) check("lat_edge3_valid", 32'(val_a), 32'd1);
        @(negedge clk);
        rd_en = 1'b0;
        tick(HALF);
        ps2_c = 1'b1;
        tick(HALF);
    endtask

    task automatic pop(input logic a, input logic b);
        @(negedge clk);
        rd_en = a;
        rd_nm = b;
        @(negedge clk);
        rd_en = 1'b0;
        rd_nm = 1'b0;
    endtask

    task automatic clear_pulse();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    initial begin
        tick(3);
        check("rst_valid", 32'(val_a), 32'd0);
        check("rst_data", 32'(data_a), 32'h00);
        check("rst_break", 32'(brk_a), 32'd0);
        check("rst_count", 32'(cnt_a), 32'd0);
        check("rst_overflow", 32'(ovf_a), 32'd0);
        check("rst_err", 32'(err_a), 32'd0);
        rst_n = 1'b1;
        tick(3);

        // Single frame with exact push latency, then pop.
        send_frame(8'h1C, 1'b0, 1'b0, 10);
        send_stop_timed(1'b1, 1'b0);
        check("one_data", 32'(data_a), 32'h1C);
        check("one_break", 32'(brk_a), 32'd0);
        check("one_count", 32'(cnt_a), 32'd1);
        pop(1'b1, 1'b1);
        check("pop_valid", 32'(val_a), 32'd0);
        check("pop_data", 32'(data_a), 32'h00);

        // Break merging on one instance, plain codes on the other.
        send_frame(8'hF0, 1'b0, 1'b0, 11);
        send_frame(8'h1C, 1'b0, 1'b0, 11);
        check("brk_count", 32'(cnt_a), 32'd1);
        check("brk_data", 32'(data_a), 32'h1C);
        check("brk_break", 32'(brk_a), 32'd1);
        check("nm_count", 32'(cnt_b), 32'd2);
        check("nm_data0", 32'(data_b), 32'hF0);
        check("nm_break0", 32'(brk_b), 32'd0);
        pop(1'b0, 1'b1);
        check("nm_data1", 32'(data_b), 32'h1C);
        check("nm_break1", 32'(brk_b), 32'd0);
        pop(1'b1, 1'b1);
        check("brk_drained", 32'(val_a), 32'd0);

        // Parity and stop-bit errors.
        send_frame(8'h1C, 1'b1, 1'b0, 11);
        send_frame(8'h1C, 1'b0, 1'b1, 11);
        check("err_count_val", 32'(cnt_a), 32'd0);
        check("err_two", 32'(err_a), 32'd2);
        clear_pulse();
        check("err_cleared", 32'(err_a), 32'd0);

        // Timeout after start + 4 data bits.
        send_frame(8'h33, 1'b0, 1'b0, 5);
        tick(100);
        check("to_before", 32'(err_a), 32'd0);
        tick(150);
        check("to_after", 32'(err_a), 32'd1);
        send_frame(8'h32, 1'b0, 1'b0, 11);
        check("to_rx_count", 32'(cnt_a), 32'd1);
        check("to_rx_data", 32'(data_a), 32'h32);
        check("to_rx_break", 32'(brk_a), 32'd0);
        pop(1'b1, 1'b1);
        clear_pulse();

        // Overflow with depth 4.
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b0, 1'b0, 11);
        check("ovf_count", 32'(cnt_a), 32'd4);
        check("ovf_flag", 32'(ovf_a), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("ovf_pop%0d", i), 32'(data_a), 32'(i));
            pop(1'b1, 1'b0);
        end
        check("ovf_empty", 32'(val_a), 32'd0);
        clear_pulse();
        check("ovf_cleared", 32'(ovf_a), 32'd0);

        // Push coinciding with pop while full.
        for (int i = 0; i < 4; i++) send_frame(8'h11 + 8'(i), 1'b0, 1'b0, 11);
        check("full_count", 32'(cnt_a), 32'd4);
        send_frame(8'h55, 1'b0, 1'b0, 10);
        send_stop_timed(1'b0, 1'b1);
        check("pp_count", 32'(cnt_a), 32'd4);
        check("pp_overflow", 32'(ovf_a), 32'd0);
        check("pp_head", 32'(data_a), 32'h12);
        pop(1'b1, 1'b0);
        check("pp_next13", 32'(data_a), 32'h13);
        pop(1'b1, 1'b0);
        check("pp_next14", 32'(data_a), 32'h14);
        pop(1'b1, 1'b0);
        check("pp_new55", 32'(data_a), 32'h55);
        pop(1'b1, 1'b0);
        check("pp_empty", 32'(val_a), 32'd0);

        // Reset in the middle of a frame.
        send_frame(8'h1C, 1'b1, 1'b0, 11);
        check("pre_rst_err", 32'(err_a), 32'd1);
        send_frame(8'h77, 1'b0, 1'b0, 6);
        @(negedge clk);
        rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(2);
        check("mid_rst_err", 32'(err_a), 32'd0);
        check("mid_rst_valid", 32'(val_a), 32'd0);
        send_frame(8'h2A, 1'b0, 1'b0, 11);
        check("mid_rx_count", 32'(cnt_a), 32'd1);
        check("mid_rx_data", 32'(data_a), 32'h2A);
        check("mid_rx_err", 32'(err_a), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ps2_scan_fifo.md
# ps2_scan_fifo

PS/2 keyboard receiver with a parametrised scan-code FIFO, parity and framing checks, frame timeout, and optional break-code merging. It sits between the board's PS/2 pins and the consuming logic, such as the VGA display or character logic, in the lab top levels. It replaces single-register scan-code capture with buffered, first-word-fall-through delivery, so that bursts of keystrokes are not lost while the consumer is busy.

## Interface
- FIFO_DEPTH, 8: number of FIFO entries; must be a power of 2, ≥ 2.
- TIMEOUT_CYCLES, 100000: Clock_50 cycles allowed between PS/2 clock falling edges inside a frame (2 ms at 50 MHz).
- BREAK_MERGE, 1: 1 = absorb 0xF0 and tag the next code as a break; 0 = push 0xF0 as an ordinary code.

Ports:
- Clock_50  in  1  system clock, 50 MHz.
- Resetn  in  1  asynchronous reset, active low.
- PS2_clock  in  1  raw PS/2 clock pin; asynchronous to Clock_50.
- PS2_data  in  1  raw PS/2 data pin; asynchronous to Clock_50.
- rd_en  in  1  pop the head entry when code_valid is 1.
- clear_err  in  1  clears overflow and err_count.
- code_data  out  8  head scan code; first-word-fall-through.
- code_break  out  1  break tag of the head entry.
- code_valid  out  1  FIFO not empty.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current number of entries.
- overflow  out  1  sticky: a push was dropped because the FIFO was full.
- err_count  out  8  saturating count of parity, stop-bit and timeout errors.

## Operation
- Pin handling: PS2_clock and PS2_data each pass through a two-flop synchroniser. A third register holds the previous synchronised clock. fall = prev & ~sync.
- FSM states:
  - S_IDLE: on fall with data = 0 (start bit), go to S_DATA with bit_cnt = 0. On fall with data = 1, stay in S_IDLE.
  - S_DATA: on each fall, shift data into shift_reg LSB first. After 8 bits, go to S_PARITY.
  - S_PARITY: on fall, capture the parity bit and go to S_STOP.
  - S_STOP: on fall, the frame is good if stop = 1 and the 9 bits (data plus parity) have odd parity. Return to S_IDLE in every case.
- Bad frame: discard the byte and increment err_count, saturating at 255. Pending-break state is unchanged.
- Timeout: a counter resets on every fall and increments otherwise, but only outside S_IDLE. When it reaches TIMEOUT_CYCLES−1, return to S_IDLE, discard the partial frame and increment err_count.
- Good frame, BREAK_MERGE = 1 and byte = 0xF0: set break_pend and push nothing.
- Good frame, any other byte: push {break_pend, byte} and clear break_pend. This applies even if the push is dropped.
- With BREAK_MERGE = 0, break_pend is never set and code_break is always 0.
- FIFO: circular buffer with FIFO_DEPTH entries of 9 bits each, and read/write pointers of $clog2(FIFO_DEPTH) bits that wrap naturally.
  - Head entry drives code_data and code_break.
  - While empty, code_data = 0x00 and code_break = 0.
- Push when full: drop the push and set overflow. The stored contents are unchanged.
- Push and pop in the same cycle: both take effect and fifo_count is unchanged. This includes the full case, where the push is accepted and overflow stays clear.
- rd_en while empty: ignored.
- clear_err: clears overflow and err_count on the next edge. If clear_err and a new error coincide, the clear wins.

## Timing
- Reset (Resetn low, asynchronous) sets:
  - state = S_IDLE; bit_cnt, shift_reg, timeout counter and pointers = 0.
  - break_pend = 0; synchronisers and previous register = 1 (idle bus).
  - Outputs: code_valid = 0, code_data = 0x00, code_break = 0, fifo_count = 0, overflow = 0, err_count = 0.
- Reset mid-frame: the partial frame is lost and reception restarts cleanly at the next start bit.
- fall asserts at the second rising edge after the pin's falling edge, once the synchroniser has propagated it.
- Push latency: the FIFO write happens on the rising edge where fall is sampled in S_STOP. code_valid and the updated fifo_count are visible after that edge, which is 3 Clock_50 edges after the stop-bit falling edge at the pin.
- Pop: with rd_en = 1 at edge N, the next entry (or the empty values) appears after edge N. This gives single-cycle back-to-back pops.
- All outputs are registered or decoded from registers. There are no combinational paths from the PS/2 pins.

## Test plan
- Reset, then send a single frame with code 0x1C and correct parity: code_valid rises 3 edges after the stop falling edge, with code_data = 0x1C, code_break = 0, fifo_count = 1. Pulse rd_en: code_valid = 0 and code_data = 0x00.
- BREAK_MERGE = 1, send 0xF0 then 0x1C: exactly one entry, code_data = 0x1C with code_break = 1. Repeat with BREAK_MERGE = 0: two entries, 0xF0 then 0x1C, both with code_break = 0.
- Send 0x1C with wrong parity, then send 0x1C with a stop bit of 0: no push, err_count = 2. Pulse clear_err: err_count = 0.
- Send the start bit plus 4 data bits, then hold the clock high: after TIMEOUT_CYCLES, err_count = 1 and state = S_IDLE. Then send a good frame with 0x32: it is received correctly.
- FIFO_DEPTH = 4: send 5 codes 0x01–0x05 without reading: fifo_count = 4 and overflow = 1. Pops return 0x01–0x04 in order. Then push while popping with the FIFO full: fifo_count stays at 4 and the new code is stored.
- Assert Resetn low during bit 5 of a frame, then send a good frame with 0x2A: only 0x2A is received and err_count = 0.
